// File: rtl/shift_add_mult16_pkg.sv
// Shared definitions for the 16-bit shift-and-add multiplier: state encoding,
// operand width, iteration count and the multiplicand gating helper.
package shift_add_mult16_pkg;

  localparam int WIDTH = 16;
  localparam int ITER  = 16;
  localparam int CNT_W = 5;

  // Value the iteration counter holds on the final RUN edge.
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [WIDTH-1:0] gate_operand(input logic [WIDTH-1:0] value,
                                                    input logic             enable);
    return enable ? value : '0;
  endfunction

endpackage

// File: rtl/shift_add_mult16_rca.sv
// 16-bit ripple-carry adder used as the multiplier's only datapath adder.
// Each bit is a plain full adder; the carry chain runs LSB to MSB.
module rca_16bits (
  input  logic [15:0] in1,
  input  logic [15:0] in2,
  input  logic        cin,
  output logic [15:0] out,
  output logic        cout
);

  logic [16:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < 16; i++) begin : g_bit
    logic half_sum;
    assign half_sum     = in1[i] ^ in2[i];
    assign out[i]       = half_sum ^ carry[i];
    assign carry[i + 1] = (in1[i] & in2[i]) | (carry[i] & half_sum);
  end

  assign cout = carry[16];

endmodule

// File: rtl/shift_add_mult16.sv
// Sequential unsigned 16x16 multiplier: one conditional add and right shift per
// cycle over 16 cycles, with a fixed latency and a single-cycle done pulse.
module shift_add_mult16
  import shift_add_mult16_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     in1,
  input  logic [WIDTH-1:0]     in2,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] s;
  logic             c;

  logic             accept;
  logic             last;

  always_comb begin
    accept = 1'b0;
    last   = 1'b0;
    if ((state == IDLE) || (state == DONE)) begin
      accept = start;
    end
    if ((state == RUN) && (cnt == LAST_ITER)) begin
      last = 1'b1;
    end
  end

  assign addend = gate_operand(mcand, lo[0]);

  rca_16bits u_adder (
    .in1  (hi),
    .in2  (addend),
    .cin  (1'b0),
    .out  (s),
    .cout (c)
  );

  // Control: state, iteration count and the registered busy/done flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST_ITER) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          if (start) begin
            state <= RUN;
            cnt   <= '0;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Datapath: the adder carry becomes the new MSB of hi, so nothing is lost
  // before the shift and the 32-bit result is exact.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand   <= '0;
      hi      <= '0;
      lo      <= '0;
      product <= '0;
    end else if (accept) begin
      mcand <= in1;
      lo    <= in2;
      hi    <= '0;
    end else if (state == RUN) begin
      hi <= {c, s[WIDTH-1:1]};
      lo <= {s[0], lo[WIDTH-1:1]};
      if (last) begin
        product <= {c, s, lo[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: tb/tb_shift_add_mult16.sv
// Directed self-checking bench for shift_add_mult16: reset, basic multiply,
// back-to-back starts, carry path, ignored starts and reset abort.
module tb_shift_add_mult16;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] in1;
  logic [15:0] in2;
  logic        busy;
  logic        done;
  logic [31:0] product;

  int checks = 0;
  int errors = 0;

  shift_add_mult16 #(.WIDTH(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .in1     (in1),
    .in2     (in2),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [15:0] a, input logic [15:0] b);
    in1   = a;
    in2   = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Called just after the accepting edge; returns edges until done and busy cycles seen.
  task automatic wait_done(output int lat, output int busy_cycles, output bit prod_changed);
    logic [31:0] p0;
    p0           = product;
    busy_cycles  = busy ? 1 : 0;
    lat          = 0;
    prod_changed = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      lat++;
      if (done) break;
      busy_cycles += busy ? 1 : 0;
      if (product !== p0) prod_changed = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in1 = 16'd0; in2 = 16'd0;
    tick(); tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    checks++; if (product !== 32'd0) begin errors++; $display("[TB] FAIL reset_product: got %0d expected 0", product); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat, bc; bit pc;
    start_op(16'd1117, 16'd232);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL basic_accept_busy: got %b expected 1", busy); end
    wait_done(lat, bc, pc);
    checks++; if (lat != 16) begin errors++; $display("[TB] FAIL basic_latency: got %0d expected 16", lat); end
    checks++; if (bc != 16) begin errors++; $display("[TB] FAIL basic_busy_cycles: got %0d expected 16", bc); end
    checks++; if (pc) begin errors++; $display("[TB] FAIL basic_product_stable: got 1 expected 0"); end
    checks++; if (product !== 32'd259144) begin errors++; $display("[TB] FAIL basic_product: got %0d expected 259144", product); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy_at_done: got %b expected 0", busy); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL basic_done_pulse: got %b expected 0", done); end
    checks++; if (product !== 32'd259144) begin errors++; $display("[TB] FAIL basic_product_hold: got %0d expected 259144", product); end
  endtask

  task automatic test_back_to_back();
    int lat, bc; bit pc;
    tick();
    start_op(16'd0, 16'd12345);
    wait_done(lat, bc, pc);
    checks++; if (lat != 16) begin errors++; $display("[TB] FAIL b2b_first_latency: got %0d expected 16", lat); end
    checks++; if (product !== 32'd0) begin errors++; $display("[TB] FAIL b2b_first_product: got %0d expected 0", product); end
    start_op(16'd12, 16'd10);
    checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_accept: got done=%b busy=%b expected done=0 busy=1", done, busy); end
    wait_done(lat, bc, pc);
    checks++; if (lat + 1 != 17) begin errors++; $display("[TB] FAIL b2b_done_spacing: got %0d expected 17", lat + 1); end
    checks++; if (pc) begin errors++; $display("[TB] FAIL b2b_product_stable: got 1 expected 0"); end
    checks++; if (product !== 32'd120) begin errors++; $display("[TB] FAIL b2b_second_product: got %0d expected 120", product); end
    tick();
  endtask

  task automatic test_carry();
    int lat, bc; bit pc;
    start_op(16'd65535, 16'd65535);
    wait_done(lat, bc, pc);
    checks++; if (lat != 16) begin errors++; $display("[TB] FAIL carry_latency: got %0d expected 16", lat); end
    checks++; if (product !== 32'hFFFE0001) begin errors++; $display("[TB] FAIL carry_product: got %h expected fffe0001", product); end
    tick();
  endtask

  task automatic test_ignore_start();
    int dones;
    dones = 0;
    start_op(16'd12, 16'd10);
    tick(); tick(); tick();
    in1 = 16'd65535; in2 = 16'd65535; start = 1'b1;
    tick(); tick();
    start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (done) begin
        dones++;
        checks++; if (product !== 32'd120) begin errors++; $display("[TB] FAIL ignore_product: got %0d expected 120", product); end
      end
      tick();
    end
    checks++; if (dones != 1) begin errors++; $display("[TB] FAIL ignore_done_count: got %0d expected 1", dones); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL ignore_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_reset_abort();
    int lat, bc, dones; bit pc;
    dones = 0;
    start_op(16'd55123, 16'd6452);
    for (int k = 0; k < 7; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || product !== 32'd0) begin
      errors++; $display("[TB] FAIL abort_outputs: got busy=%b done=%b product=%0d expected 0 0 0", busy, done, product);
    end
    for (int k = 0; k < 20; k++) begin
      tick();
      if (done) dones++;
    end
    checks++; if (dones != 0) begin errors++; $display("[TB] FAIL abort_no_done: got %0d expected 0", dones); end
    start_op(16'd46143, 16'd10000);
    wait_done(lat, bc, pc);
    checks++; if (lat != 16) begin errors++; $display("[TB] FAIL abort_next_latency: got %0d expected 16", lat); end
    checks++; if (product !== 32'd461430000) begin errors++; $display("[TB] FAIL abort_next_product: got %0d expected 461430000", product); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_carry();
    test_ignore_start();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_add_mult16.md
SHIFT_ADD_MULT16 -- requirements
Module: shift_add_mult16

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, operand width; only 16 is supported because the datapath adder is rca_16bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 The block SHALL have port start, input, 1, request to begin a multiply; sampled only in IDLE or DONE.
REQ-005 The block SHALL have port in1, input, 16, unsigned multiplicand; captured on the accepting edge.
REQ-006 The block SHALL have port in2, input, 16, unsigned multiplier; captured on the accepting edge.
REQ-007 The block SHALL have port busy, output, 1, high while in RUN.
REQ-008 The block SHALL have port done, output, 1, single-cycle pulse marking product valid.
REQ-009 The block SHALL have port product, output, 32, unsigned in1*in2 result, registered.

Function
REQ-010 The FSM SHALL have states IDLE, RUN and DONE.
- IDLE->RUN on start=1.
- RUN->DONE after 16 iterations.
- DONE->RUN on start=1, else DONE->IDLE.
REQ-011 The accepting edge SHALL load mcand<=in1, lo<=in2, hi<=0, cnt<=0 and set busy=1 for the following cycle.
REQ-012 Each RUN edge SHALL perform one iteration:
- {c,s} = hi + (lo[0] ? mcand : 0) via rca_16bits with cin=0.
- {hi,lo} <= {c,s,lo} >> 1.
- cnt <= cnt+1.
REQ-013 On the 16th RUN edge the block SHALL write product <= {hi,lo} post-shift, assert done=1, deassert busy and enter DONE.
REQ-014 Latency SHALL be fixed: start sampled at edge E gives done=1 exactly in the cycle between edges E+16 and E+17, independent of operand values.
REQ-015 done SHALL be high for exactly one cycle per accepted start.
REQ-016 product SHALL hold its value until the next completion; it SHALL NOT change during RUN.
REQ-017 start asserted while busy=1 SHALL be ignored, and in1/in2 changes during RUN SHALL have no effect.
REQ-018 start=1 in the DONE cycle SHALL be accepted (back-to-back), with done and busy obeying REQ-011/REQ-013.
REQ-019 The adder carry-out SHALL never be discarded; {c,s} is 17 bits before the shift, so the full 32-bit product is exact for all operands, including 65535*65535.

Reset
REQ-020 rst=1 at an edge SHALL force state IDLE, busy=0, done=0, product=0, hi=0, lo=0, mcand=0, cnt=0.
REQ-021 rst SHALL take priority over start and over any in-flight iteration; an aborted multiply SHALL produce no done pulse.
REQ-022 The first start SHALL be accepted at the first edge with rst=0.

Structure
REQ-023 A shared package SHALL hold the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2), WIDTH=16, and ITER=16.
REQ-024 The block SHALL instantiate exactly one rca_16bits as its datapath adder, connected as in1=hi, in2=gated mcand, cin=0, out=s, cout=c; no behavioural "+" on the datapath.
REQ-025 The counter SHALL be 5 bits; control SHALL be a single FSM process separate from the datapath registers.

Verification
REQ-026 in1=1117, in2=232, start pulse -> done after 16 cycles, product=259144, busy high for exactly 16 cycles.
REQ-027 in1=65535, in2=65535 -> product=32'hFFFE0001 (carry-out path exercised).
REQ-028 in1=0, in2=12345, then in1=12, in2=10 issued back-to-back in the DONE cycle -> product=0, then product=120, two done pulses 17 cycles apart.
REQ-029 Start with 55123*6452, then rst=1 at RUN cycle 8 -> all outputs 0 next cycle, no done; subsequent 46143*10000 -> product=461430000.
REQ-030 Start with 12*10, then start=1 with in1=in2=65535 during RUN -> ignored; product=120, single done.
